// File: rtl/kij_sched_pkg.sv
// Shared types and window-length helpers for the multi-kij layer sequencer.
package kij_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_FILL  = 3'd1,
    W_LOAD  = 3'd2,
    A_FILL  = 3'd3,
    COMPUTE = 3'd4,
    DRAIN   = 3'd5,
    NEXT    = 3'd6,
    DONE    = 3'd7
  } state_t;

  // Core kernel-load window, counted from the start_kernel_load pulse cycle.
  function automatic int LOAD_WIN(input int c);
    return 3 * c + 1;
  endfunction

  // Core MAC window, counted from the start_mac_compute pulse cycle.
  function automatic int COMP_WIN(input int nij, input int c);
    return nij + 2 * c + 1;
  endfunction

endpackage

// File: rtl/sched_ptr_cnt.sv
// Loadable address pointer that increments on inc, plus a clearable row counter.
// tc is high once the counter equals cnt_last; pointer wraps modulo 2^PTR_W.
module sched_ptr_cnt #(
  parameter int PTR_W = 11,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ptr_load,
  input  logic [PTR_W-1:0] ptr_base,
  input  logic             cnt_clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] cnt_last,
  output logic [PTR_W-1:0] ptr,
  output logic             tc
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (ptr_load)  ptr_d = ptr_base;
    else if (inc)  ptr_d = ptr_q + 1'b1;
    if (cnt_clr)   cnt_d = '0;
    else if (inc)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ptr = ptr_q;
  assign tc  = (cnt_q == cnt_last);

endmodule

// File: rtl/kij_scheduler.sv
// Runs all NUM_KIJ kernel positions: xmem->L0 fills, core pulses, OFIFO->pmem drain.
// xmem/pmem strobes are registered (1-cycle lag); reads stall on l0_full, drain follows ofifo_valid.
module kij_scheduler
  import kij_sched_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int NUM_KIJ = 9,
  parameter int XADDR_W = 11,
  parameter int PADDR_W = 11,
  parameter int W_BASE  = 0,
  parameter int A_BASE  = 128,
  parameter int P_BASE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         num_nij,
  output logic               busy,
  output logic               done,
  output logic               xmem_rd,
  output logic [XADDR_W-1:0] xmem_addr,
  output logic               l0_wr,
  input  logic               l0_full,
  output logic               core_start_kernel_load,
  output logic               core_start_mac_compute,
  output logic [7:0]         core_num_nij,
  input  logic               ofifo_valid,
  output logic               ofifo_rd,
  output logic               pmem_wr,
  output logic [PADDR_W-1:0] pmem_addr,
  output logic [3:0]         kij_idx
);

  if (row < 1 || col < 1 || col > 255 || NUM_KIJ < 1 || NUM_KIJ > 16) begin : g_param_check
    $error("kij_scheduler: unsupported parameter set");
  end

  state_t             state_q, state_d;
  logic [3:0]         kij_q, kij_d;
  logic [7:0]         nij_q, nij_d;
  logic [9:0]         wait_q, wait_d;
  logic               xmem_rd_q, xmem_rd_d;
  logic [XADDR_W-1:0] xmem_addr_q, xmem_addr_d;
  logic               l0_wr_q, l0_wr_d;
  logic               pmem_wr_q, pmem_wr_d;
  logic [PADDR_W-1:0] pmem_addr_q, pmem_addr_d;

  logic               ptr_load, cnt_clr, w_inc, a_inc, p_inc;
  logic               w_tc, a_tc, p_tc;
  logic [XADDR_W-1:0] w_ptr, a_ptr;
  logic [PADDR_W-1:0] p_ptr;

  sched_ptr_cnt #(.PTR_W(XADDR_W), .CNT_W(8)) u_w_ptr (
    .clk(clk), .reset(reset), .ptr_load(ptr_load), .ptr_base(XADDR_W'(W_BASE)),
    .cnt_clr(cnt_clr), .inc(w_inc), .cnt_last(8'(col)), .ptr(w_ptr), .tc(w_tc)
  );

  sched_ptr_cnt #(.PTR_W(XADDR_W), .CNT_W(8)) u_a_ptr (
    .clk(clk), .reset(reset), .ptr_load(ptr_load), .ptr_base(XADDR_W'(A_BASE)),
    .cnt_clr(cnt_clr), .inc(a_inc), .cnt_last(nij_q), .ptr(a_ptr), .tc(a_tc)
  );

  // The psum counter counts OFIFO reads; each read becomes exactly one pmem write a cycle later.
  sched_ptr_cnt #(.PTR_W(PADDR_W), .CNT_W(8)) u_p_ptr (
    .clk(clk), .reset(reset), .ptr_load(ptr_load), .ptr_base(PADDR_W'(P_BASE)),
    .cnt_clr(cnt_clr), .inc(p_inc), .cnt_last(nij_q), .ptr(p_ptr), .tc(p_tc)
  );

  assign ofifo_rd = !reset && (state_q == DRAIN) && ofifo_valid && !p_tc;
  assign p_inc    = ofifo_rd;

  always_comb begin
    state_d     = state_q;
    kij_d       = kij_q;
    nij_d       = nij_q;
    wait_d      = '0;
    xmem_rd_d   = 1'b0;
    xmem_addr_d = xmem_addr_q;
    l0_wr_d     = xmem_rd_q;
    pmem_wr_d   = ofifo_rd;
    pmem_addr_d = ofifo_rd ? p_ptr : pmem_addr_q;
    ptr_load    = 1'b0;
    cnt_clr     = 1'b0;
    w_inc       = 1'b0;
    a_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          nij_d    = num_nij;
          kij_d    = '0;
          ptr_load = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = (num_nij == 8'd0) ? DONE : W_FILL;
        end
      end
      // Fills leave once all reads are issued and the last one has reached L0.
      W_FILL: begin
        if (!w_tc && !l0_full) begin
          xmem_rd_d   = 1'b1;
          xmem_addr_d = w_ptr;
          w_inc       = 1'b1;
        end
        if (w_tc && !xmem_rd_q) state_d = W_LOAD;
      end
      W_LOAD: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == 10'(LOAD_WIN(col) - 1)) state_d = A_FILL;
      end
      A_FILL: begin
        if (!a_tc && !l0_full) begin
          xmem_rd_d   = 1'b1;
          xmem_addr_d = a_ptr;
          a_inc       = 1'b1;
        end
        if (a_tc && !xmem_rd_q) state_d = COMPUTE;
      end
      COMPUTE: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == 10'(COMP_WIN(int'(nij_q), col) - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (p_tc) state_d = NEXT;
      end
      NEXT: begin
        cnt_clr = 1'b1;
        if (kij_q == 4'(NUM_KIJ - 1)) begin
          state_d = DONE;
        end else begin
          kij_d   = kij_q + 1'b1;
          state_d = W_FILL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kij_q       <= '0;
      nij_q       <= '0;
      wait_q      <= '0;
      xmem_rd_q   <= 1'b0;
      xmem_addr_q <= '0;
      l0_wr_q     <= 1'b0;
      pmem_wr_q   <= 1'b0;
      pmem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      kij_q       <= kij_d;
      nij_q       <= nij_d;
      wait_q      <= wait_d;
      xmem_rd_q   <= xmem_rd_d;
      xmem_addr_q <= xmem_addr_d;
      l0_wr_q     <= l0_wr_d;
      pmem_wr_q   <= pmem_wr_d;
      pmem_addr_q <= pmem_addr_d;
    end
  end

  assign busy                   = (state_q != IDLE) && (state_q != DONE);
  assign done                   = (state_q == DONE);
  assign xmem_rd                = xmem_rd_q;
  assign xmem_addr              = xmem_addr_q;
  assign l0_wr                  = l0_wr_q;
  assign core_start_kernel_load = (state_q == W_LOAD) && (wait_q == '0);
  assign core_start_mac_compute = (state_q == COMPUTE) && (wait_q == '0);
  assign core_num_nij           = nij_q;
  assign pmem_wr                = pmem_wr_q;
  assign pmem_addr              = pmem_addr_q;
  assign kij_idx                = kij_q;

endmodule
